// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Fetches 16-bit big-endian instructions as two sequential byte
//               reads from a byte-wide memory and buffers them in a small
//               prefetch FIFO presented through a valid/ready interface.
//               Optional macro INSTR_FETCH_PERF_EN adds perf_fetched and
//               perf_stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_addr,
    output logic        mem_cs,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    input  logic        bus_gnt,
    output logic        bus_req,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr_pc
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_stall
`endif
);

    localparam int c_aw = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int c_cw = c_aw + 1;
    localparam logic [c_cw-1:0] c_depth = c_cw'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        S_REQ_HI = 2'd0,
        S_CAP_HI = 2'd1,
        S_REQ_LO = 2'd2,
        S_CAP_LO = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_pc;
    logic [7:0]      r_hi_byte;
    logic [15:0]     r_addr;
    logic [15:0]     w_req_addr;
    logic            w_push;
    logic            w_pop;
    logic            w_has_slot;

    logic [15:0]     r_q_instr [QUEUE_DEPTH];
    logic [15:0]     r_q_pc    [QUEUE_DEPTH];
    logic [c_aw-1:0] r_wptr;
    logic [c_aw-1:0] r_rptr;
    logic [c_cw-1:0] r_count;

    assign mem_we      = 1'b0;
    assign instr_valid = (r_count != '0);
    assign instr       = instr_valid ? r_q_instr[r_rptr] : 16'h0000;
    assign instr_pc    = instr_valid ? r_q_pc[r_rptr]    : 16'h0000;
    assign w_pop       = instr_valid & instr_ready;
    // A slot freed by a pop this cycle may be claimed by a new request.
    assign w_has_slot  = (r_count < c_depth) | w_pop;

    // Next-state, bus request and memory address; reset/redirect quiet the bus.
    always_comb begin
        w_state_nxt = r_state;
        bus_req     = 1'b0;
        w_req_addr  = r_pc;
        w_push      = 1'b0;
        case (r_state)
            S_REQ_HI: begin
                bus_req    = w_has_slot;
                w_req_addr = r_pc;
                if (w_has_slot && bus_gnt) begin
                    w_state_nxt = S_CAP_HI;
                end
            end
            S_CAP_HI: begin
                bus_req     = 1'b1;
                w_req_addr  = r_pc + 16'd1;
                w_state_nxt = bus_gnt ? S_CAP_LO : S_REQ_LO;
            end
            S_REQ_LO: begin
                bus_req    = 1'b1;
                w_req_addr = r_pc + 16'd1;
                if (bus_gnt) begin
                    w_state_nxt = S_CAP_LO;
                end
            end
            S_CAP_LO: begin
                w_push      = 1'b1;
                w_state_nxt = S_REQ_HI;
            end
            default: w_state_nxt = S_REQ_HI;
        endcase
        if (rst || redirect_valid) begin
            bus_req     = 1'b0;
            w_push      = 1'b0;
            w_state_nxt = S_REQ_HI;
        end
        mem_cs   = bus_req & bus_gnt;
        mem_addr = mem_cs ? w_req_addr : r_addr;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ_HI;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fetch PC, captured high byte and held memory address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_hi_byte <= 8'h00;
            r_addr    <= 16'h0000;
        end else begin
            if (redirect_valid) begin
                r_pc <= redirect_pc;
            end else if (w_push) begin
                r_pc <= r_pc + 16'd2;
            end
            if (r_state == S_CAP_HI) begin
                r_hi_byte <= mem_rdata;
            end
            if (mem_cs) begin
                r_addr <= w_req_addr;
            end
        end
    end

    // FIFO pointers and occupancy; redirect flushes ahead of push and pop.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are only visible while the count is non-zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wptr] <= {r_hi_byte, mem_rdata};
            r_q_pc[r_wptr]    <= r_pc;
        end
    end

`ifdef INSTR_FETCH_PERF_EN
    logic [15:0] r_perf_fetched;
    logic [15:0] r_perf_stall;

    // Push and stall counters; free-running, untouched by redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= 16'h0000;
            r_perf_stall   <= 16'h0000;
        end else begin
            if (w_push) begin
                r_perf_fetched <= r_perf_fetched + 16'd1;
            end
            if (bus_req && !bus_gnt) begin
                r_perf_stall <= r_perf_stall + 16'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Scoreboard bench for instr_fetch with a byte-wide memory
//               model; expected instructions are queued by the stimulus and
//               compared by an independent monitor on every accepted pop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic [15:0] mem_addr;
    logic        mem_cs;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        bus_gnt;
    logic        bus_req;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_pc;
`ifdef INSTR_FETCH_PERF_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_stall;
`endif

    logic [7:0]  mem [0:65535];
    logic [31:0] sb [$];
    int          total;
    int          bad;

    instr_fetch #(.RESET_PC(16'h0000), .QUEUE_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_cs         (mem_cs),
        .mem_we         (mem_we),
        .mem_rdata      (mem_rdata),
        .bus_gnt        (bus_gnt),
        .bus_req        (bus_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_pc       (instr_pc)
`ifdef INSTR_FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read data one cycle after an accepted request.
    always @(posedge clk) begin
        if (mem_cs) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted instruction must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && !redirect_valid && instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_instr: got instr=%h pc=%h expected none", instr, instr_pc);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                chk("sb_instr", {16'h0, instr}, {16'h0, e[31:16]});
                chk("sb_pc", {16'h0, instr_pc}, {16'h0, e[15:0]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain_wait();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            step();
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
        instr_ready = 1'b0;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        bus_gnt        = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'hE5;
        mem[0] = 8'h50; mem[1] = 8'h00; mem[2] = 8'h12; mem[3] = 8'h34;
        mem[4] = 8'h9A; mem[5] = 8'hBC;
        mem[16'h0100] = 8'h77; mem[16'h0101] = 8'h88;

        // Reset values
        step();
        #1;
        chk("rst_mem_cs", mem_cs, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_we", mem_we, 0);
        step();

        // Basic fetch: 5000 at cycle 3, 1234 at cycle 6
        rst = 1'b0;
        instr_ready = 1'b1;
        sb.push_back({16'h5000, 16'h0000});
        sb.push_back({16'h1234, 16'h0002});
        #1;
        chk("c0_mem_cs", mem_cs, 1);
        chk("c0_mem_addr", mem_addr, 16'h0000);
        step(); step();
        chk("c2_valid", instr_valid, 0);
        step();
        chk("c3_valid", instr_valid, 1);
        chk("c3_instr", instr, 16'h5000);
        step(); step();
        chk("c5_valid", instr_valid, 0);
        step();
        chk("c6_valid", instr_valid, 1);
        chk("c6_instr", instr, 16'h1234);
        chk("c6_pc", instr_pc, 16'h0002);
        step();
        instr_ready = 1'b0;
        chk("t1_sb_empty", sb.size(), 0);

        // Backpressure: queue fills, bus_req drops, head stays stable
        reset_dut();
        sb.push_back({16'h5000, 16'h0000});
        sb.push_back({16'h1234, 16'h0002});
        sb.push_back({16'h9ABC, 16'h0004});
        repeat (6) step();
        for (int k = 0; k < 5; k++) begin
            chk("full_bus_req", bus_req, 0);
            chk("full_mem_cs", mem_cs, 0);
            chk("full_instr", instr, 16'h5000);
            chk("full_valid", instr_valid, 1);
            step();
        end
        instr_ready = 1'b1;
        #1;
        chk("full_pop_req", bus_req, 1);
        drain_wait();

        // Grant withheld in REQ_LO
        reset_dut();
        instr_ready = 1'b1;
        sb.push_back({16'h5000, 16'h0000});
        step();
        for (int k = 0; k < 4; k++) begin
            bus_gnt = 1'b0;
            #1;
            chk("stall_mem_cs", mem_cs, 0);
            chk("stall_bus_req", bus_req, 1);
            chk("stall_addr", mem_addr, 16'h0000);
            step();
        end
        bus_gnt = 1'b1;
        #1;
        chk("resume_cs", mem_cs, 1);
        chk("resume_addr", mem_addr, 16'h0001);
        drain_wait();

        // Redirect during CAP_HI with one entry queued
        reset_dut();
        repeat (4) step();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        #1;
        chk("redir_queued", instr_valid, 1);
        chk("redir_bus_req", bus_req, 0);
        chk("redir_mem_cs", mem_cs, 0);
        step();
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        sb.push_back({16'h7788, 16'h0100});
        #1;
        chk("redir_flushed", instr_valid, 0);
        drain_wait();

        // Address wrap at 16'hFFFF
        reset_dut();
        mem[16'hFFFF] = 8'hAB;
        mem[16'h0000] = 8'hCD;
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        #1;
        chk("wrap_redir_req", bus_req, 0);
        step();
        redirect_valid = 1'b0;
        sb.push_back({16'hABCD, 16'hFFFF});
        sb.push_back({16'h0012, 16'h0001});
        drain_wait();

        // Reset in CAP_LO
        reset_dut();
        step(); step();
        rst = 1'b1;
        step();
        chk("rst2_mem_cs", mem_cs, 0);
        chk("rst2_bus_req", bus_req, 0);
        chk("rst2_mem_addr", mem_addr, 0);
        chk("rst2_valid", instr_valid, 0);
        chk("rst2_instr", instr, 0);
        chk("rst2_pc", instr_pc, 0);
        step();
        rst = 1'b0;
        instr_ready = 1'b1;
        sb.push_back({16'hCD00, 16'h0000});
        drain_wait();

        step();
        chk("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
